// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART byte receiver.
// Optional even-parity support is selected by UART_RX_PARITY_EN.
package uart_pkg;

  localparam int unsigned BAUD_DEF       = 115200;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Clock cycles per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_IN     = 120000000,
  parameter int unsigned BAUD       = BAUD_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned DIV = calc_div(CLK_IN, BAUD, OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (restart || cnt_q == CNT_MAX) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_rx_byte.sv
// Oversampling 8N1 UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_IN     = 120000000,
  parameter int unsigned BAUD       = BAUD_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  input  logic       ready_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       frame_err_out,
  output logic       overrun_out,
  output logic       parity_err_out
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);

  logic            rx_meta_q, rx_s_q;
  logic [1:0]      prime_q;
  logic            armed_q, armed_d;
  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      samp_q, samp_d, samp_nx;
  logic            sample_now, maj, tick_c;
  logic            restart_c, done_c, ferr_c;
`ifdef UART_RX_PARITY_EN
  logic            par_err_q, par_err_d, perr_c;
`endif

  // Synchronizer; prime_q marks when rx_s_q reflects real line samples after reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      prime_q   <= 2'b00;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      prime_q   <= {prime_q[0], 1'b1};
    end
  end

  uart_baud_tick #(
    .CLK_IN    (CLK_IN),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .restart(restart_c),
    .tick_c (tick_c)
  );

  assign sample_now = (s_q == S_LO) || (s_q == S_MID) || (s_q == S_HI);
  assign samp_nx    = sample_now ? {samp_q[1:0], rx_s_q} : samp_q;
  assign maj        = (samp_nx[0] & samp_nx[1]) | (samp_nx[0] & samp_nx[2]) |
                      (samp_nx[1] & samp_nx[2]);

  // Next-state and datapath decisions.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    armed_d   = armed_q | (rx_s_q & prime_q[1]);
    restart_c = 1'b0;
    done_c    = 1'b0;
    ferr_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
    perr_c    = 1'b0;
`endif
    if (tick_c && state_q != ST_IDLE) begin
      samp_d = samp_nx;
      s_d    = (s_q == S_LAST) ? '0 : s_q + SW'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (armed_q && !rx_s_q) begin
          state_d   = ST_START;
          s_d       = '0;
          restart_c = 1'b1;
        end
      end
      ST_START: begin
        if (tick_c && s_q == S_LAST) begin
          state_d = maj ? ST_IDLE : ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick_c && s_q == S_LAST) begin
          shift_d = {maj, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_c && s_q == S_LAST) begin
          par_err_d = ^{shift_q, maj};
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Decide at mid-stop so the next start bit can follow immediately.
        if (tick_c && s_q == S_HI) begin
          state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
          if (par_err_q)  perr_c = 1'b1;
          else if (!maj)  ferr_c = 1'b1;
          else            done_c = 1'b1;
`else
          if (!maj)       ferr_c = 1'b1;
          else            done_c = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      s_q       <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      samp_q    <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      s_q       <= s_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Holding register: a completion while full is accepted only if the old byte leaves.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_out      <= 8'h00;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      frame_err_out <= ferr_c;
      overrun_out   <= done_c && valid_out && !ready_in;
      if (done_c && (!valid_out || ready_in)) begin
        data_out  <= shift_q;
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) parity_err_out <= 1'b0;
    else        parity_err_out <= perr_c;
  end
`else
  assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: expected events queued as frames are sent.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ  = 3686400;
  localparam int unsigned BAUD_R  = 115200;
  localparam int unsigned OS      = 16;
  localparam int unsigned BIT_CYC = 32;  // DIV = 2 clocks per tick, 16 ticks per bit
  localparam logic [7:0] K_BYTE = 8'h01;
  localparam logic [7:0] K_FRM  = 8'h02;
  localparam logic [7:0] K_OVR  = 8'h03;
  localparam logic [7:0] K_PAR  = 8'h04;

  logic       clk_in;
  logic       rst_in;
  logic       rx_in;
  logic       ready_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err_out;
  logic       overrun_out;
  logic       parity_err_out;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];

  uart_rx_byte #(
    .CLK_IN    (CLK_HZ),
    .BAUD      (BAUD_R),
    .OVERSAMPLE(OS)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rx_in         (rx_in),
    .ready_in      (ready_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .frame_err_out (frame_err_out),
    .overrun_out   (overrun_out),
    .parity_err_out(parity_err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic note_event(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
    chk(tag, obs, e);
  endtask

  // Observe outputs mid-cycle; each handshake or pulse is one event.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (valid_out && ready_in) note_event("byte", {K_BYTE, data_out});
      if (frame_err_out)         note_event("frame_err", {K_FRM, 8'h00});
      if (overrun_out)           note_event("overrun", {K_OVR, 8'h00});
      if (parity_err_out)        note_event("parity_err", {K_PAR, 8'h00});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_cyc(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
    rx_in = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] d, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_b);
    send_bit(1'b1);
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in   = 1'b1;
    rx_in    = 1'b1;
    ready_in = 1'b1;
    wait_cyc(3);
    chk("rst_valid", 16'(valid_out), 16'h0);
    chk("rst_data", 16'(data_out), 16'h0);
    chk("rst_ferr", 16'(frame_err_out), 16'h0);
    chk("rst_ovr", 16'(overrun_out), 16'h0);
    chk("rst_perr", 16'(parity_err_out), 16'h0);
    rst_in = 1'b0;
    wait_cyc(10);

    // Plain byte with consumer ready
    exp_q.push_back({K_BYTE, 8'hA5});
    send_frame(8'hA5, 1'b1);
    wait_cyc(40);
    chk("a5_valid_cleared", 16'(valid_out), 16'h0);

    // Overrun: second byte dropped, first kept
    ready_in = 1'b0;
    send_frame(8'h3C, 1'b1);
    exp_q.push_back({K_OVR, 8'h00});
    send_frame(8'h7E, 1'b1);
    wait_cyc(40);
    chk("ovr_data_kept", 16'(data_out), 16'h003C);
    chk("ovr_valid_held", 16'(valid_out), 16'h1);
    exp_q.push_back({K_BYTE, 8'h3C});
    ready_in = 1'b1;
    wait_cyc(1);
    chk("ovr_valid_drop", 16'(valid_out), 16'h0);
    wait_cyc(20);

    // Short glitch on idle line is a false start
    rx_in = 1'b0;
    wait_cyc(8);
    rx_in = 1'b1;
    wait_cyc(40);
    chk("glitch_idle", 16'(dut.state_q), 16'(ST_IDLE));
    chk("glitch_no_valid", 16'(valid_out), 16'h0);
    exp_q.push_back({K_BYTE, 8'h12});
    send_frame(8'h12, 1'b1);
    wait_cyc(40);

    // Bad stop bit
    exp_q.push_back({K_FRM, 8'h00});
    send_frame(8'h55, 1'b0);
    wait_cyc(64);
    chk("ferr_no_valid", 16'(valid_out), 16'h0);

    // Reset during data bit 3, released with the line still low
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    wait_cyc(10);
    rst_in = 1'b1;
    wait_cyc(2);
    chk("midrst_data", 16'(data_out), 16'h0);
    chk("midrst_state", 16'(dut.state_q), 16'(ST_IDLE));
    wait_cyc(3);
    rst_in = 1'b0;
    wait_cyc(60);
    chk("unarmed_idle", 16'(dut.state_q), 16'(ST_IDLE));
    rx_in = 1'b1;
    wait_cyc(40);
    exp_q.push_back({K_BYTE, 8'h81});
    send_frame(8'h81, 1'b1);
    wait_cyc(40);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back({K_PAR, 8'h00});
    send_par(8'h01, 1'b0);
    wait_cyc(40);
    chk("perr_no_valid", 16'(valid_out), 16'h0);
    exp_q.push_back({K_BYTE, 8'h01});
    send_par(8'h01, 1'b1);
    wait_cyc(40);
`endif

    chk("events_pending", 16'(exp_q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
